// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared single-port instruction/data memory.
// Master 0 has priority, master 1 is protected by a starvation limit, and either may lock the bus.
module mem_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 10,
   parameter int STARVE_LIM = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m0_gnt,
   output logic              m1_gnt,
   output logic              m0_rvalid,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner
);

   // state | meaning
   // IDLE  | no lock held, arbitrate every cycle
   // LOCK0 | master 0 owns the bus, master 1 ignored
   // LOCK1 | master 1 owns the bus, master 0 ignored

   localparam int SC_RAW = $clog2(STARVE_LIM + 1);
   localparam int SC_W   = (SC_RAW < 2) ? 2 : SC_RAW;
   localparam logic [SC_W-1:0] SC_LIM = SC_W'(STARVE_LIM);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   state_t            state;
   logic [SC_W-1:0]   starve_cnt;
   logic              rd_pend;
   logic              rd_owner;
   logic [DATA_W-1:0] rdata_q;
   logic              win0;
   logic              win1;
   logic              gnt0;
   logic              gnt1;

   always_comb begin
      win0 = 1'b0;
      win1 = 1'b0;
      unique case (state)
         IDLE: begin
            if (m0_req && m1_req) begin
               if (starve_cnt == SC_LIM) win1 = 1'b1;
               else                      win0 = 1'b1;
            end else begin
               win0 = m0_req;
               win1 = m1_req;
            end
         end
         LOCK0:   win0 = 1'b1;
         LOCK1:   win1 = 1'b1;
         default: ;
      endcase
   end

   // Grants are forced low while reset is held, even though reset is async.
   assign gnt0 = rst & m0_req & win0;
   assign gnt1 = rst & m1_req & win1;

   assign m0_gnt    = gnt0;
   assign m1_gnt    = gnt1;
   assign mem_we    = (gnt0 & m0_we) | (gnt1 & m1_we);
   assign mem_addr  = !rst ? '0 : (gnt1 ? m1_addr  : m0_addr);
   assign mem_wdata = !rst ? '0 : (gnt1 ? m1_wdata : m0_wdata);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         owner      <= 2'b00;
         starve_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (gnt1 || !m1_req)
                  starve_cnt <= '0;
               else if (gnt0 && starve_cnt != SC_LIM)
                  starve_cnt <= starve_cnt + SC_W'(1);
               if (gnt0 && m0_lock) begin
                  state <= LOCK0;
                  owner <= 2'b01;
               end else if (gnt1 && m1_lock) begin
                  state <= LOCK1;
                  owner <= 2'b10;
               end
            end
            LOCK0: begin
               if ((gnt0 && !m0_lock) || (!m0_req && !m0_lock)) begin
                  state <= IDLE;
                  owner <= 2'b00;
               end
            end
            LOCK1: begin
               if ((gnt1 && !m1_lock) || (!m1_req && !m1_lock)) begin
                  state <= IDLE;
                  owner <= 2'b00;
               end
            end
            default: begin
               state <= IDLE;
               owner <= 2'b00;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_pend  <= 1'b0;
         rd_owner <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rd_pend <= (gnt0 & ~m0_we) | (gnt1 & ~m1_we);
         if ((gnt0 & ~m0_we) | (gnt1 & ~m1_we))
            rd_owner <= gnt1;
         if (rd_pend)
            rdata_q <= mem_rdata;
      end
   end

   // Memory read data passes straight through on the return cycle; otherwise the last value is held.
   assign m0_rvalid = rd_pend & ~rd_owner;
   assign m1_rvalid = rd_pend &  rd_owner;
   assign rdata     = rd_pend ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, all checked against
// a transaction-level model of lock holder, starvation count, pending read and memory contents.
module tb_mem_arbiter;
   localparam int AW  = 8;
   localparam int DW  = 10;
   localparam int LIM = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we;
   logic [DW-1:0] rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;
   logic [1:0]    owner;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .owner(owner)
   );

   always #5 clk = ~clk;

   // Synchronous single-port memory with a preload path used while reset is held.
   logic [DW-1:0] tb_mem [256];
   logic          pl_en;
   logic [AW-1:0] pl_addr;
   logic [DW-1:0] pl_data;
   always @(posedge clk) begin
      if (pl_en) tb_mem[pl_addr] <= pl_data;
      else if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      mem_rdata <= tb_mem[mem_addr];
   end

   // Reference model: lk 0 = free, 1 = m0 holds lock, 2 = m1 holds lock.
   int            lk, sc, pown;
   bit            pend;
   logic [DW-1:0] pdata, last_rd;
   logic [DW-1:0] shadow [256];
   int            checks = 0;
   int            failures = 0;

   logic          obs_g0, obs_g1, obs_rv0, obs_rv1;
   logic [DW-1:0] obs_rdata;
   logic [1:0]    obs_owner;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic rv, input logic r0, input logic w0, input logic l0,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic r1, input logic w1, input logic l1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      logic          e_g0, e_g1, e_we, npend;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd, e_rd;
      rst = rv;
      m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
      if (!rv) begin
         lk = 0; sc = 0; pend = 0; pown = 0; last_rd = '0;
      end
      #1;
      e_g0 = 1'b0;
      e_g1 = 1'b0;
      if (rv) begin
         if (lk == 1)           e_g0 = r0;
         else if (lk == 2)      e_g1 = r1;
         else if (r0 && r1) begin
            if (sc == LIM) e_g1 = 1'b1;
            else           e_g0 = 1'b1;
         end else begin
            e_g0 = r0;
            e_g1 = r1;
         end
      end
      e_addr = !rv ? '0 : (e_g1 ? a1 : a0);
      e_wd   = !rv ? '0 : (e_g1 ? d1 : d0);
      e_we   = (e_g0 && w0) || (e_g1 && w1);
      e_rd   = pend ? pdata : last_rd;
      obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_rv0 = m0_rvalid; obs_rv1 = m1_rvalid;
      obs_rdata = rdata; obs_owner = owner;
      chk("m0_gnt", 32'(m0_gnt), 32'(e_g0));
      chk("m1_gnt", 32'(m1_gnt), 32'(e_g1));
      chk("mem_we", 32'(mem_we), 32'(e_we));
      chk("mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      chk("m0_rvalid", 32'(m0_rvalid), 32'(pend && pown == 0));
      chk("m1_rvalid", 32'(m1_rvalid), 32'(pend && pown == 1));
      chk("rdata", 32'(rdata), 32'(e_rd));
      chk("owner", 32'(owner), 32'(lk));
      if (rv) begin
         last_rd = e_rd;
         npend = (e_g0 && !w0) || (e_g1 && !w1);
         if (npend) begin
            pown  = e_g1 ? 1 : 0;
            pdata = shadow[e_g1 ? a1 : a0];
         end
         pend = npend;
         if (e_g0 && w0) shadow[a0] = d0;
         if (e_g1 && w1) shadow[a1] = d1;
         if (lk == 0) begin
            if (e_g1 || !r1)          sc = 0;
            else if (e_g0 && sc < LIM) sc = sc + 1;
            if (e_g0 && l0)      lk = 1;
            else if (e_g1 && l1) lk = 2;
         end else if (lk == 1) begin
            if ((e_g0 && !l0) || (!r0 && !l0)) lk = 0;
         end else begin
            if ((e_g1 && !l1) || (!r1 && !l1)) lk = 0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic rd0(input logic [AW-1:0] a);
      step(1'b1, 1'b1, 1'b0, 1'b0, a, '0, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      logic [DW-1:0] v;
      rst = 1'b0;
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
      lk = 0; sc = 0; pend = 0; pown = 0; pdata = '0; last_rd = '0;
      pl_en = 1'b1; pl_addr = '0; pl_data = '0;
      @(negedge clk);
      for (int i = 0; i < 256; i++) begin
         v = (i == 'h12) ? 10'h2A5 : DW'($urandom);
         pl_addr = AW'(i);
         pl_data = v;
         shadow[i] = v;
         @(negedge clk);
      end
      pl_en = 1'b0;

      // reset with both requests high, then release with only m0 requesting
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 10'h001, 1'b1, 1'b1, 1'b0, 8'h02, 10'h002);
      chk("rst_gnt_any", 32'(obs_g0 | obs_g1), 32'd0);
      rd0(8'h33);
      chk("rel_m0_gnt", 32'(obs_g0), 32'd1);

      // single read of preloaded word
      rd0(8'h12);
      idle();
      chk("single_rv0", 32'(obs_rv0), 32'd1);
      chk("single_rdata", 32'(obs_rdata), 32'h2A5);
      chk("single_rv1", 32'(obs_rv1), 32'd0);

      // continuous contention: m1 wins every fourth cycle
      idle();
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, AW'($urandom), '0, 1'b1, 1'b0, 1'b0, AW'($urandom), '0);
         chk("starve_seq", 32'(obs_g1), 32'((k % 4) == 3));
      end

      // locked write then read by m1 while m0 keeps requesting
      idle();
      for (int k = 0; k < 4; k++)
         step(1'b1, 1'b1, 1'b0, 1'b0, 8'h40, '0, 1'b1, 1'b1, 1'b1, 8'h05, 10'h3FF);
      chk("lock_wr_gnt", 32'(obs_g1), 32'd1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h40, '0, 1'b1, 1'b0, 1'b0, 8'h05, '0);
      chk("lock_m0_blocked", 32'(obs_g0), 32'd0);
      chk("lock_owner", 32'(obs_owner), 32'h2);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h40, '0, 1'b0, 1'b0, 1'b0, '0, '0);
      chk("lock_m0_after", 32'(obs_g0), 32'd1);
      chk("lock_rd_data", 32'(obs_rdata), 32'h3FF);
      chk("lock_rv1", 32'(obs_rv1), 32'd1);

      // back-to-back reads
      idle();
      rd0(8'h00);
      rd0(8'h01);
      chk("b2b_rv0_a", 32'(obs_rv0), 32'd1);
      rd0(8'h02);
      chk("b2b_rv0_b", 32'(obs_rv0), 32'd1);
      idle();
      chk("b2b_rv0_c", 32'(obs_rv0), 32'd1);

      // m0 read followed by m1 write
      rd0(8'h20);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 8'h10, 10'h155);
      chk("mix_rv0", 32'(obs_rv0), 32'd1);
      idle();
      chk("mix_no_rv", 32'(obs_rv0 | obs_rv1), 32'd0);

      // reset while a read is pending and while a lock is held
      rd0(8'h21);
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
      chk("rst_pend_lost", 32'(obs_rv0), 32'd0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h22, '0, 1'b0, 1'b0, 1'b0, '0, '0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h23, '0, 1'b1, 1'b0, 1'b0, 8'h24, '0);
      chk("lock0_owner", 32'(obs_owner), 32'h1);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'h23, '0, 1'b1, 1'b0, 1'b0, 8'h24, '0);
      idle();
      chk("rst_lock_drop", 32'(obs_owner), 32'h0);

      // random traffic over a small address window
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 59) != 0),
              ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 5) == 0),
              AW'($urandom_range(0, 15)), DW'($urandom),
              ($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 5) == 0),
              AW'($urandom_range(0, 15)), DW'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
